// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction-memory word address, registers
// the returned word toward decode, follows JMP locally and takes execute redirects.
module instr_fetch #(
  parameter int unsigned MEM_DEPTH   = 11,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  JMP_OPCODE  = 6'h02,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        addr_err,
  output logic [15:0] fetch_count
);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        addr_err_q, addr_err_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [5:0]  opcode;
  logic [31:0] pc_inc;
  logic [15:0] count_inc;

  assign opcode    = instruction[31:26];
  assign pc_inc    = (pc_q == 32'(MEM_DEPTH) - 32'd1) ? 32'd0 : pc_q + 32'd1;
  assign count_inc = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    addr_err_d    = addr_err_q;
    fetch_count_d = fetch_count_q;
    if (state_q == S_HALT) begin
      instr_valid_d = 1'b0;
    end else if (redir_valid) begin
      // Redirect wins over stall so a taken branch is never lost.
      pc_d          = redir_target;
      instr_valid_d = 1'b0;
    end else if (stall) begin
      instr_valid_d = instr_valid_q;
    end else if (pc_q >= 32'(MEM_DEPTH)) begin
      addr_err_d    = 1'b1;
      state_d       = S_HALT;
      instr_valid_d = 1'b0;
    end else if (opcode == JMP_OPCODE) begin
      pc_d          = {7'b0, instruction[24:0]};
      instr_valid_d = 1'b0;
    end else begin
      instr_out_d   = instruction;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      fetch_count_d = count_inc;
      if (opcode == HALT_OPCODE) state_d = S_HALT;
      else                       pc_d    = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign address     = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == S_HALT);
  assign addr_err    = addr_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand sequences for error/halt/reset,
// then randomized programs checked against a cycle-level reference of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] address;
  logic [31:0] instruction;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        addr_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:31];

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_pc, m_out, m_ipc;
  logic        m_v, m_halt, m_err;
  int          m_cnt;

  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .address(address), .instruction(instruction),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .addr_err(addr_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always_comb instruction = (address < 32'd32) ? mem[address[4:0]] : 32'h0;

  typedef struct {
    logic        s, rv;
    logic [31:0] rt;
    logic [31:0] e_addr, e_out, e_pc;
    logic        e_v;
    logic [15:0] e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_out = '0; m_ipc = '0; m_v = 1'b0;
    m_halt = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the fetch rules, evaluated on the pre-edge state.
  task automatic model_edge(input logic s, input logic rv, input logic [31:0] rt);
    logic [31:0] w;
    if (m_halt) begin
      m_v = 1'b0;
    end else if (rv) begin
      m_pc = rt; m_v = 1'b0;
    end else if (s) begin
      // hold everything
    end else if (m_pc >= 11) begin
      m_err = 1'b1; m_halt = 1'b1; m_v = 1'b0;
    end else begin
      w = mem[m_pc[4:0]];
      if (w[31:26] == 6'h02) begin
        m_pc = {7'b0, w[24:0]}; m_v = 1'b0;
      end else begin
        m_out = w; m_ipc = m_pc; m_v = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (w[31:26] == 6'h3F) m_halt = 1'b1;
        else m_pc = (m_pc + 1) % 11;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".address"},     address,            m_pc);
    chk({tag, ".instr_out"},   instr_out,          m_out);
    chk({tag, ".instr_pc"},    instr_pc,           m_ipc);
    chk({tag, ".instr_valid"}, 32'(instr_valid),   32'(m_v));
    chk({tag, ".halted"},      32'(halted),        32'(m_halt));
    chk({tag, ".addr_err"},    32'(addr_err),      32'(m_err));
    chk({tag, ".fetch_count"}, 32'(fetch_count),   32'(m_cnt));
  endtask

  task automatic step(input string tag, input logic s, input logic rv, input logic [31:0] rt);
    stall = s; redir_valid = rv; redir_target = rt;
    model_edge(s, rv, rt);
    @(posedge clk); #1;
    compare_all(tag);
  endtask

  // Called 1 time unit after an edge; outputs must clear while reset is high.
  task automatic do_reset(input string tag);
    stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
    reset = 1'b1;
    #2;
    model_reset();
    compare_all(tag);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int r;
    r = int'($urandom_range(0, 99));
    w = $urandom;
    if (r < 8) begin
      w = {6'h02, 1'b0, 25'($urandom_range(0, 12))};
    end else if (r < 11) begin
      w[31:26] = 6'h3F;
    end else if (w[31:26] == 6'h02 || w[31:26] == 6'h3F) begin
      w[31:26] = 6'h10;
    end
    return w;
  endfunction

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'd0, 32'd1,  32'hA000_0000, 32'd0,  1'b1, 16'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'd0, 32'd5,  32'hA000_0000, 32'd0,  1'b0, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 32'd0, 32'd6,  32'hA000_0005, 32'd5,  1'b1, 16'd2};
    vecs[3]  = '{1'b0, 1'b0, 32'd0, 32'd7,  32'hA000_0006, 32'd6,  1'b1, 16'd3};
    vecs[4]  = '{1'b1, 1'b0, 32'd0, 32'd7,  32'hA000_0006, 32'd6,  1'b1, 16'd3};
    vecs[5]  = '{1'b1, 1'b0, 32'd0, 32'd7,  32'hA000_0006, 32'd6,  1'b1, 16'd3};
    vecs[6]  = '{1'b1, 1'b1, 32'd8, 32'd8,  32'hA000_0006, 32'd6,  1'b0, 16'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'd0, 32'd9,  32'hA000_0008, 32'd8,  1'b1, 16'd4};
    vecs[8]  = '{1'b0, 1'b0, 32'd0, 32'd10, 32'hA000_0009, 32'd9,  1'b1, 16'd5};
    vecs[9]  = '{1'b0, 1'b0, 32'd0, 32'd0,  32'hA000_000A, 32'd10, 1'b1, 16'd6};
    vecs[10] = '{1'b0, 1'b0, 32'd0, 32'd1,  32'hA000_0000, 32'd0,  1'b1, 16'd7};
    vecs[11] = '{1'b0, 1'b0, 32'd0, 32'd5,  32'hA000_0000, 32'd0,  1'b0, 16'd7};
    vecs[12] = '{1'b0, 1'b1, 32'd3, 32'd3,  32'hA000_0000, 32'd0,  1'b0, 16'd7};
    vecs[13] = '{1'b0, 1'b0, 32'd0, 32'd4,  32'hA000_0003, 32'd3,  1'b1, 16'd8};

    // Directed table: linear fetch, JMP bubble, stall hold, redirect in stall, wrap.
    fill_linear();
    mem[1] = 32'h0800_0005;
    #1;
    do_reset("reset0");
    for (int i = 0; i < 14; i++) begin
      stall = vecs[i].s; redir_valid = vecs[i].rv; redir_target = vecs[i].rt;
      model_edge(vecs[i].s, vecs[i].rv, vecs[i].rt);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.address", i),     address,          vecs[i].e_addr);
      chk($sformatf("vec%0d.instr_out", i),   instr_out,        vecs[i].e_out);
      chk($sformatf("vec%0d.instr_pc", i),    instr_pc,         vecs[i].e_pc);
      chk($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d.fetch_count", i), 32'(fetch_count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.halted", i),      32'(halted),      32'd0);
    end

    // JMP beyond memory: accepted, error and halt one cycle later, PC frozen.
    fill_linear();
    mem[3] = 32'h0800_0014;
    do_reset("reset_jmp");
    for (int i = 0; i < 4; i++) step("jmp20_run", 1'b0, 1'b0, 32'd0);
    chk("jmp20.pc_taken", address, 32'd20);
    step("jmp20_err", 1'b0, 1'b0, 32'd0);
    chk("jmp20.addr_err", 32'(addr_err), 32'd1);
    chk("jmp20.halted", 32'(halted), 32'd1);
    step("jmp20_frozen", 1'b0, 1'b1, 32'd2);
    step("jmp20_frozen2", 1'b0, 1'b0, 32'd0);
    chk("jmp20.pc_frozen", address, 32'd20);

    // HALT issued once, then mid-run reset restarts at Mem[0].
    fill_linear();
    mem[2] = 32'hFC00_0000;
    do_reset("reset_halt");
    for (int i = 0; i < 3; i++) step("halt_run", 1'b0, 1'b0, 32'd0);
    chk("halt.issued_valid", 32'(instr_valid), 32'd1);
    chk("halt.issued_word", instr_out, 32'hFC00_0000);
    chk("halt.halted", 32'(halted), 32'd1);
    step("halt_idle", 1'b0, 1'b0, 32'd0);
    chk("halt.valid_dropped", 32'(instr_valid), 32'd0);
    chk("halt.count", 32'(fetch_count), 32'd3);
    do_reset("reset_midrun");
    step("restart", 1'b0, 1'b0, 32'd0);
    chk("restart.word", instr_out, 32'hA000_0000);

    // Randomized programs against the reference.
    for (int round = 0; round < 8; round++) begin
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
      do_reset($sformatf("rnd%0d_reset", round));
      for (int cyc = 0; cyc < 200; cyc++) begin
        logic s, rv;
        logic [31:0] rt;
        s  = ($urandom_range(0, 99) < 20);
        rv = ($urandom_range(0, 99) < 6);
        rt = 32'($urandom_range(0, 12));
        if (round == 3 && cyc == 60) do_reset("rnd_midrun_reset");
        step($sformatf("rnd%0d_c%0d", round, cyc), s, rv, rt);
        if (m_halt && cyc > 0 && $urandom_range(0, 3) == 0) break;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
